// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous tile/sprite ROM between two viewport fetchers.
// Optional MEM_ARB_STATS_EN adds contention and starvation statistics outputs.
module tile_rom_arbiter #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 24
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          frame_start,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          vld0,
    output logic          vld1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [7:0]    starve_max
`endif
);

    logic          contention;
    logic          last_q, last_d;
    logic          mem_rd_q;
    logic [AW-1:0] mem_addr_q;
    logic          tag1_vld_q, tag1_id_q;
    logic          tag2_vld_q, tag2_id_q;
    logic          vld0_q, vld1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    // last_q names the requester that won the previous contention; the other one wins next.
    always_comb begin
        contention = req0 & req1;
        gnt0       = req0 & (~req1 | last_q);
        gnt1       = req1 & (~req0 | ~last_q);
        last_d     = last_q;
        if (frame_start) begin
            last_d = 1'b1;
        end else if (contention) begin
            last_d = ~last_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_q     <= 1'b1;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            tag1_vld_q <= 1'b0;
            tag1_id_q  <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag2_id_q  <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            last_q     <= last_d;
            mem_rd_q   <= gnt0 | gnt1;
            if (gnt0) begin
                mem_addr_q <= addr0;
            end else if (gnt1) begin
                mem_addr_q <= addr1;
            end
            tag1_vld_q <= gnt0 | gnt1;
            tag1_id_q  <= gnt1;
            // Stage 2 tag travels alongside the ROM access cycle.
            tag2_vld_q <= tag1_vld_q;
            tag2_id_q  <= tag1_id_q;
            vld0_q     <= tag2_vld_q & ~tag2_id_q;
            vld1_q     <= tag2_vld_q & tag2_id_q;
            if (tag2_vld_q && !tag2_id_q) begin
                rdata0_q <= mem_rdata;
            end
            if (tag2_vld_q && tag2_id_q) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign vld0     = vld0_q;
    assign vld1     = vld1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic [7:0]  wait0_q, wait0_d, wait1_q, wait1_d;
    logic [7:0]  starve_q, starve_d;

    always_comb begin
        conflict_d = conflict_q;
        if (contention && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
        wait0_d = '0;
        if (req0 && !gnt0) begin
            wait0_d = (wait0_q == 8'hFF) ? 8'hFF : wait0_q + 8'd1;
        end
        wait1_d = '0;
        if (req1 && !gnt1) begin
            wait1_d = (wait1_q == 8'hFF) ? 8'hFF : wait1_q + 8'd1;
        end
        starve_d = starve_q;
        if (wait0_d > starve_d) begin
            starve_d = wait0_d;
        end
        if (wait1_d > starve_d) begin
            starve_d = wait1_d;
        end
        // A frame boundary restarts every statistic, even if this cycle is contended.
        if (frame_start) begin
            conflict_d = '0;
            wait0_d    = '0;
            wait1_d    = '0;
            starve_d   = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            conflict_q <= '0;
            wait0_q    <= '0;
            wait1_q    <= '0;
            starve_q   <= '0;
        end else begin
            conflict_q <= conflict_d;
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
            starve_q   <= starve_d;
        end
    end

    assign conflict_cnt = conflict_q;
    assign starve_max   = starve_q;
`endif

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Scoreboard bench for tile_rom_arbiter: directed stimulus queues expected reads, a
// negedge monitor checks ROM strobes and returned words against them.
module tb_tile_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [12:0] addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, vld0, vld1, mem_rd;
    logic [23:0] rdata0, rdata1;
    logic [12:0] mem_addr;
    logic [23:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [7:0]  starve_max;
`endif

    tile_rom_arbiter #(.AW(13), .DW(24)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .req0        (req0),
        .req1        (req1),
        .addr0       (addr0),
        .addr1       (addr1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .vld0        (vld0),
        .vld1        (vld1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .starve_max  (starve_max)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t qa[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [23:0] rom(input logic [12:0] a);
        return {~a[10:0], a};
    endfunction

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= rom(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_chk(input string name, input logic [23:0] act, inout exp_t q[$]);
        exp_t e;
        chk({name, "_expected"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({name, "_data"}, 32'(act), 32'(e.data));
            chk({name, "_cycle"}, cyc, e.due);
        end
    endtask

    task automatic drop_late(input string name, inout exp_t q[$]);
        while (q.size() != 0 && q[0].due < cyc) begin
            chk({name, "_missing"}, cyc, q[0].due);
            void'(q.pop_front());
        end
    endtask

    // Monitor: every returned word and every ROM strobe must match a queued expectation.
    always @(negedge Clk) begin
        if (Reset_n) begin
            drop_late("vld0", q0);
            drop_late("vld1", q1);
            drop_late("mem_rd", qa);
            if (vld0) pop_chk("vld0", rdata0, q0);
            if (vld1) pop_chk("vld1", rdata1, q1);
            if (mem_rd) pop_chk("mem_addr", 24'(mem_addr), qa);
            if (gnt0 && gnt1) chk("gnt_onehot", 32'({gnt0, gnt1}), 32'd2);
        end
    end

    task automatic drive(input logic r0, input logic [12:0] a0, input logic r1,
                         input logic [12:0] a1, input logic fs, input logic e0, input logic e1);
        @(posedge Clk);
        #1;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; frame_start = fs;
        @(negedge Clk);
        chk("gnt0", 32'(gnt0), 32'(e0));
        chk("gnt1", 32'(gnt1), 32'(e1));
        if (e0) begin
            q0.push_back('{rom(a0), cyc + 3});
            qa.push_back('{24'(a0), cyc + 1});
        end
        if (e1) begin
            q1.push_back('{rom(a1), cyc + 3});
            qa.push_back('{24'(a1), cyc + 1});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [12:0] a0, a1;
        // Reset state: with last=1, contention grants view 0.
        req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd1);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_vld", 32'({vld0, vld1}), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Single read from view 0.
        drive(1'b1, 13'h010, 1'b0, 13'h0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("t1_mem_rd", 32'(mem_rd), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h010);
        idle(3);
        chk("t1_rdata0_hold", 32'(rdata0), 32'(rom(13'h010)));
        chk("t1_mem_rd_idle", 32'(mem_rd), 32'd0);
        chk("t1_mem_addr_hold", 32'(mem_addr), 32'h010);

        // Continuous contention: strict alternation starting with view 0.
        a0 = 13'h100; a1 = 13'h200;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, a0, 1'b1, a1, 1'b0, (i % 2) == 0, (i % 2) == 1);
            if ((i % 2) == 0) a0++; else a1++;
        end
        idle(4);

        // last=0 after one contention; frame_start with only req1 restores view-0 priority.
        drive(1'b1, 13'h300, 1'b1, 13'h400, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 13'h000, 1'b1, 13'h401, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 13'h301, 1'b1, 13'h402, 1'b0, 1'b1, 1'b0);
        // Contention in a frame_start cycle uses the old last (0), then last becomes 1.
        drive(1'b1, 13'h302, 1'b1, 13'h403, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 13'h302, 1'b1, 13'h404, 1'b0, 1'b1, 1'b0);
        idle(4);

        // req1 loses twice then gives up: it must never reach the ROM.
        drive(1'b1, 13'h500, 1'b0, 13'h000, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 13'h501, 1'b1, 13'h1FFF, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 13'h502, 1'b1, 13'h1FFF, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 13'h503, 1'b0, 13'h000, 1'b0, 1'b1, 1'b0);
        idle(5);

        // Asynchronous reset one cycle after two back-to-back grants.
        drive(1'b1, 13'h020, 1'b0, 13'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 13'h021, 1'b0, 13'h0, 1'b0, 1'b1, 1'b0);
        @(posedge Clk);
        #1;
        req0 = 1'b0;
        Reset_n = 1'b0;
        #1;
        q0.delete(); q1.delete(); qa.delete();
        chk("ar_rdata0", 32'(rdata0), 32'd0);
        chk("ar_rdata1", 32'(rdata1), 32'd0);
        chk("ar_mem_rd", 32'(mem_rd), 32'd0);
        chk("ar_vld", 32'({vld0, vld1}), 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(5);
        chk("ar_rdata0_after", 32'(rdata0), 32'd0);
        drive(1'b1, 13'h050, 1'b1, 13'h060, 1'b0, 1'b1, 1'b0);
        idle(5);

`ifdef MEM_ARB_STATS_EN
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 13'(i), 1'b1, 13'(i + 'h800), 1'b0, (i % 2) == 0, (i % 2) == 1);
        end
        idle(1);
        chk("st_conflict", 32'(conflict_cnt), 32'd300);
        chk("st_starve", 32'(starve_max), 32'd1);
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("st_conflict_clr", 32'(conflict_cnt), 32'd0);
        chk("st_starve_clr", 32'(starve_max), 32'd0);
        idle(4);
`endif

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("qa_drained", qa.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
